// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read-side arbiter (and a future write-side twin).
//   arb_state_e  : arbiter FSM encodings
//   burst_cnt_w  : width of a counter that must reach burst_max inclusive
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  function automatic int burst_cnt_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_prio_sel.sv
// rr_prio_sel: combinational round-robin first-one finder.
// Scans req upward starting at ptr, wrapping modulo P_NUM_CH.
//   req : request vector, one bit per channel
//   ptr : highest-priority channel index
//   idx : first requesting channel at or after ptr (0 when none)
//   any : at least one request present
module rr_prio_sel #(
  parameter int P_NUM_CH = 4,
  parameter int P_CH_MSB = 1
) (
  input  logic [P_NUM_CH-1:0] req,
  input  logic [P_CH_MSB:0]   ptr,
  output logic [P_CH_MSB:0]   idx,
  output logic                any
);

  assign any = |req;

  always_comb begin
    logic found;
    int   c;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < P_NUM_CH; i++) begin
      c = (int'(ptr) + i) % P_NUM_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c[P_CH_MSB:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares one valid/ready consumer among P_NUM_CH FWFT async-FIFO
// read controllers with round-robin grants and bursts capped at P_BURST_MAX.
//   i_clk, i_rst : read-domain clock, synchronous active-high reset
//   i_empty      : registered empty flag per channel
//   i_rd_data    : FWFT read data, channel c at [c*(P_DATA_MSB+1) +: P_DATA_MSB+1]
//   o_inc        : one-hot pop strobe to each read controller
//   o_valid/o_data/o_ch/i_ready : registered output stage tagged with source channel
//   o_busy       : a channel is currently granted
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int P_NUM_CH    = 4,
  parameter int P_CH_MSB    = 1,
  parameter int P_DATA_MSB  = 31,
  parameter int P_BURST_MAX = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [P_NUM_CH-1:0]                i_empty,
  input  logic [P_NUM_CH*(P_DATA_MSB+1)-1:0] i_rd_data,
  output logic [P_NUM_CH-1:0]                o_inc,
  output logic                               o_valid,
  output logic [P_DATA_MSB:0]                o_data,
  output logic [P_CH_MSB:0]                  o_ch,
  input  logic                               i_ready,
  output logic                               o_busy
);

  localparam int                DW         = P_DATA_MSB + 1;
  localparam int                BW         = burst_cnt_w(P_BURST_MAX);
  localparam logic [P_CH_MSB:0] LAST_CH    = (P_CH_MSB+1)'(P_NUM_CH - 1);
  localparam logic [BW-1:0]     BURST_LAST = BW'(P_BURST_MAX);

  arb_state_e        state, state_nxt;
  logic [P_CH_MSB:0] grant, grant_nxt, rr_ptr, rr_ptr_nxt, sel_idx, grant_inc;
  logic [BW-1:0]     burst_cnt, burst_cnt_nxt;
  logic              sel_any, slot_free, load;

  rr_prio_sel #(.P_NUM_CH(P_NUM_CH), .P_CH_MSB(P_CH_MSB)) u_sel (
    .req (~i_empty),
    .ptr (rr_ptr),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Explicit wrap: P_NUM_CH need not be a power of two.
  assign grant_inc = (grant == LAST_CH) ? '0 : grant + 1'b1;
  assign slot_free = ~o_valid | i_ready;
  assign o_busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    load          = 1'b0;
    o_inc         = '0;
    case (state)
      ST_IDLE: begin
        if (sel_any) begin
          grant_nxt     = sel_idx;
          burst_cnt_nxt = '0;
          state_nxt     = ST_POP;
        end
      end
      ST_POP: begin
        if (i_empty[grant]) begin
          rr_ptr_nxt = grant_inc;
          state_nxt  = ST_IDLE;
        end else if (slot_free) begin
          load           = 1'b1;
          o_inc[grant]   = 1'b1;
          burst_cnt_nxt  = burst_cnt + 1'b1;
          state_nxt      = ST_WAIT;
        end
      end
      // One idle cycle after every pop: the empty flag lags the read pointer by
      // two edges, so popping back-to-back could underflow the FIFO.
      ST_WAIT: begin
        if (burst_cnt == BURST_LAST) begin
          rr_ptr_nxt = grant_inc;
          state_nxt  = ST_IDLE;
        end else begin
          state_nxt  = ST_POP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (i_rst) begin
      load  = 1'b0;
      o_inc = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Load wins over accept so a stream of pops never inserts a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= i_rd_data[grant*DW +: DW];
      o_ch    <= grant;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter (4 channels, burst cap 4).
// A small FIFO model per channel supplies FWFT data and an empty flag that
// lags the read pointer by two edges; expected output words are queued by
// the stimulus in hand-derived order and compared by a negedge monitor.
module tb_fifo_rd_arbiter;

  localparam int NCH = 4, CHW = 2, DW = 32, BMAX = 4, DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    empty_q = '1;
  logic [NCH*DW-1:0] rd_data;
  logic [NCH-1:0]    inc;
  logic              valid, ready, busy;
  logic [DW-1:0]     data;
  logic [CHW-1:0]    ch;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(
    .P_NUM_CH(NCH), .P_CH_MSB(CHW-1), .P_DATA_MSB(DW-1), .P_BURST_MAX(BMAX)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_empty   (empty_q),
    .i_rd_data (rd_data),
    .o_inc     (inc),
    .o_valid   (valid),
    .o_data    (data),
    .o_ch      (ch),
    .i_ready   (ready),
    .o_busy    (busy)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem [NCH][DEPTH];
  int wr_cnt [NCH] = '{default: 0};
  int rd_idx [NCH] = '{default: 0};

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      empty_q[c] <= (wr_cnt[c] == rd_idx[c]);
      if (inc[c]) rd_idx[c] <= rd_idx[c] + 1;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) rd_data[c*DW +: DW] = mem[c][rd_idx[c] % DEPTH];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("inc_onehot", 64'($countones(inc) <= 1), 64'd1);
    for (int c = 0; c < NCH; c++)
      if (inc[c]) chk("pop_nonempty", 64'(wr_cnt[c] > rd_idx[c]), 64'd1);
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got ch %0d data %h, expected none", ch, data);
      end else begin
        e = exp_q.pop_front();
        chk("out_ch", 64'(ch), 64'(e.ch));
        chk("out_data", 64'(data), 64'(e.data));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [DW-1:0] d);
    mem[c][wr_cnt[c] % DEPTH] = d;
    wr_cnt[c] = wr_cnt[c] + 1;
  endtask

  task automatic expect_word(input int c, input logic [DW-1:0] d);
    exp_t e;
    e.ch   = CHW'(c);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      tick();
      k++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [NCH-1:0] sc_inc  [9] = '{4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
  logic           sc_busy [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int k;
    ready = 1'b1;

    // Reset with every channel holding one word.
    for (int c = 0; c < NCH; c++) begin
      put(c, 32'hD000_0000 + c);
      expect_word(c, 32'hD000_0000 + c);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_inc", 64'(inc), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_idle_inc", 64'(inc), 64'd0);
    chk("rel_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("rel_first_pop", 64'(inc), 64'h1);
    drain("reset_drain");

    // Single channel: alternate-cycle pops, then release.
    put(2, 32'hA); put(2, 32'hB); put(2, 32'hC);
    expect_word(2, 32'hA); expect_word(2, 32'hB); expect_word(2, 32'hC);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("single_inc_%0d", i), 64'(inc), 64'(sc_inc[i]));
      chk($sformatf("single_busy_%0d", i), 64'(busy), 64'(sc_busy[i]));
    end
    drain("single");

    // Wrap fairness: pointer now at 3, so order 3,0,1,2.
    for (int c = 0; c < NCH; c++) begin
      put(c, 32'hC000_0000 + (c << 4));
      put(c, 32'hC000_0001 + (c << 4));
    end
    for (int j = 0; j < NCH; j++) begin
      expect_word((j + 3) % NCH, 32'hC000_0000 + (((j + 3) % NCH) << 4));
      expect_word((j + 3) % NCH, 32'hC000_0001 + (((j + 3) % NCH) << 4));
    end
    drain("wrap");

    // Burst cap: ch0/ch1 with 10 words alternate in bursts of 4,4,2.
    for (int j = 0; j < 10; j++) begin
      put(0, 32'h0B00_0000 + j);
      put(1, 32'h1B00_0000 + j);
    end
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 2; c++)
        for (int j = 0; j < ((s < 2) ? 4 : 2); j++)
          expect_word(c, (c == 0 ? 32'h0B00_0000 : 32'h1B00_0000) + s * 4 + j);
    drain("burst");

    // Back-pressure on ch2 (pointer now 2).
    ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      put(2, 32'hE000_0000 + j);
      expect_word(2, 32'hE000_0000 + j);
    end
    k = 0;
    while (!valid && k < 20) begin
      tick();
      k++;
    end
    chk("bp_first_valid", 64'(valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 64'(valid), 64'd1);
      chk("bp_hold_data", 64'(data), 64'hE000_0000);
      chk("bp_hold_inc", 64'(inc), 64'd0);
    end
    ready = 1'b1;
    #1;
    chk("bp_accept_and_pop", 64'(inc), 64'h4);
    drain("backpressure");

    // Mid-burst reset while ch1 sits in the gap cycle (pointer now 3).
    for (int j = 0; j < 4; j++) put(1, 32'hF000_0000 + j);
    expect_word(1, 32'hF000_0000);
    k = 0;
    while (!inc[1] && k < 20) begin
      tick();
      k++;
    end
    chk("mr_first_pop", 64'(inc), 64'h2);
    tick();
    rst = 1'b1;
    put(0, 32'h6000_0000);
    #1;
    chk("mr_rst_inc", 64'(inc), 64'd0);
    tick();
    chk("mr_valid", 64'(valid), 64'd0);
    chk("mr_inc", 64'(inc), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    expect_word(0, 32'h6000_0000);
    for (int j = 1; j < 4; j++) expect_word(1, 32'hF000_0000 + j);
    tick();
    chk("mr_restart_ch0", 64'(inc), 64'h1);
    drain("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
